ysyx_24110015_mem_arbiter: RTL and testbench

YSYX_24110015_MEM_ARBITER -- requirements
Module: ysyx_24110015_mem_arbiter

---
 rtl/ysyx_24110015_mem_arbiter_if.sv | 50 +++++
 rtl/ysyx_24110015_mem_arbiter.sv | 113 +++++++++++
 tb/tb_ysyx_24110015_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24110015_mem_arbiter_if.sv
// Bundle of the IFU, LSU and downstream memory handshakes seen by the arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface ysyx_24110015_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MaskW = DATA_W / 8;

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_rsp_valid;
    logic [DATA_W-1:0] ifu_rdata;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MaskW-1:0]  lsu_wmask;
    logic              lsu_rsp_valid;
    logic [DATA_W-1:0] lsu_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MaskW-1:0]  mem_wmask;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_24110015_mem_arbiter.sv
// Two-requester (IFU/LSU) round-robin arbiter onto a single memory port,
// one transaction outstanding at a time.
module ysyx_24110015_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_24110015_mem_arbiter_if.master   bus,
    output logic                          busy
);
    localparam int unsigned MaskW = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;  // 1: LSU owns the transaction
    logic              last_q, last_d;    // 1: LSU was granted last
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MaskW-1:0]  wmask_q, wmask_d;

    logic ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid;
    logic pick_lsu;

    // LSU wins if it is alone, or if both contend and IFU was served last.
    assign pick_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_q);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        mem_req_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.ifu_req_valid || bus.lsu_req_valid) begin
                    state_d = StReq;
                    owner_d = pick_lsu;
                    last_d  = pick_lsu;
                    if (pick_lsu) begin
                        lsu_req_ready = 1'b1;
                        addr_d        = bus.lsu_addr;
                        wen_d         = bus.lsu_wen;
                        wdata_d       = bus.lsu_wdata;
                        wmask_d       = bus.lsu_wmask;
                    end else begin
                        ifu_req_ready = 1'b1;
                        addr_d        = bus.ifu_addr;
                        wen_d         = 1'b0;
                        wdata_d       = '0;
                        wmask_d       = '0;
                    end
                end
            end
            StReq: begin
                mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.mem_rsp_valid) begin
                    ifu_rsp_valid = !owner_q;
                    lsu_rsp_valid = owner_q;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    assign bus.ifu_req_ready = ifu_req_ready;
    assign bus.lsu_req_ready = lsu_req_ready;
    assign bus.ifu_rsp_valid = ifu_rsp_valid;
    assign bus.lsu_rsp_valid = lsu_rsp_valid;
    assign bus.ifu_rdata     = bus.mem_rdata;
    assign bus.lsu_rdata     = bus.mem_rdata;
    assign bus.mem_req_valid = mem_req_valid;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;
    assign busy              = (state_q != StIdle);
endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: a transaction-level model is
// checked every cycle, plus literal expectations for the key scenarios.
module tb_ysyx_24110015_mem_arbiter;
    logic clk;
    logic rst;
    logic busy;
    int   n_vec;
    int   n_err;

    ysyx_24110015_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    ysyx_24110015_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if.master),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.ifu_req_valid = 1'b0;
        bus_if.ifu_addr      = '0;
        bus_if.lsu_req_valid = 1'b0;
        bus_if.lsu_addr      = '0;
        bus_if.lsu_wen       = 1'b0;
        bus_if.lsu_wdata     = '0;
        bus_if.lsu_wmask     = '0;
        bus_if.mem_req_ready = 1'b0;
        bus_if.mem_rsp_valid = 1'b0;
        bus_if.mem_rdata     = '0;
    endtask

    // Transaction-level model: phase 0 = no transaction, 1 = issuing, 2 = awaiting data.
    int          m_phase;
    logic        m_owner_lsu;
    logic        m_last_lsu;
    logic [31:0] m_addr;
    logic        m_wen;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;

    initial begin
        logic has_req, winner_lsu;
        logic e_ifu_rdy, e_lsu_rdy, e_ifu_rsp, e_lsu_rsp;
        m_phase = 0; m_owner_lsu = 1'b0; m_last_lsu = 1'b0;
        m_addr = '0; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            has_req = bus_if.ifu_req_valid || bus_if.lsu_req_valid;
            if (bus_if.ifu_req_valid && bus_if.lsu_req_valid) winner_lsu = !m_last_lsu;
            else winner_lsu = bus_if.lsu_req_valid;
            e_ifu_rdy = (m_phase == 0) && has_req && !winner_lsu;
            e_lsu_rdy = (m_phase == 0) && has_req && winner_lsu;
            e_ifu_rsp = (m_phase == 2) && bus_if.mem_rsp_valid && !m_owner_lsu;
            e_lsu_rsp = (m_phase == 2) && bus_if.mem_rsp_valid && m_owner_lsu;

            chkb("model ifu_req_ready", bus_if.ifu_req_ready, e_ifu_rdy);
            chkb("model lsu_req_ready", bus_if.lsu_req_ready, e_lsu_rdy);
            chkb("model ifu_rsp_valid", bus_if.ifu_rsp_valid, e_ifu_rsp);
            chkb("model lsu_rsp_valid", bus_if.lsu_rsp_valid, e_lsu_rsp);
            chkb("model mem_req_valid", bus_if.mem_req_valid, m_phase == 1);
            chkb("model busy", busy, m_phase != 0);
            chk("model mem_addr", bus_if.mem_addr, m_addr);
            chkb("model mem_wen", bus_if.mem_wen, m_wen);
            chk("model mem_wdata", bus_if.mem_wdata, m_wdata);
            chk("model mem_wmask", 32'(bus_if.mem_wmask), 32'(m_wmask));
            if (e_ifu_rsp) chk("model ifu_rdata", bus_if.ifu_rdata, bus_if.mem_rdata);
            if (e_lsu_rsp) chk("model lsu_rdata", bus_if.lsu_rdata, bus_if.mem_rdata);

            if (rst) begin
                m_phase = 0; m_owner_lsu = 1'b0; m_last_lsu = 1'b0;
                m_addr = '0; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
            end else if (m_phase == 0 && has_req) begin
                m_phase     = 1;
                m_owner_lsu = winner_lsu;
                m_last_lsu  = winner_lsu;
                m_addr      = winner_lsu ? bus_if.lsu_addr : bus_if.ifu_addr;
                m_wen       = winner_lsu ? bus_if.lsu_wen : 1'b0;
                m_wdata     = winner_lsu ? bus_if.lsu_wdata : 32'h0;
                m_wmask     = winner_lsu ? bus_if.lsu_wmask : 4'h0;
            end else if (m_phase == 1 && bus_if.mem_req_ready) begin
                m_phase = 2;
            end else if (m_phase == 2 && bus_if.mem_rsp_valid) begin
                m_phase = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        chkb("reset busy", busy, 1'b0);
        chkb("reset mem_req_valid", bus_if.mem_req_valid, 1'b0);
        chk("reset mem_addr", bus_if.mem_addr, 32'h0);
        rst = 1'b0;

        // Single fetch: accept N, request N+1, response N+2, idle N+3.
        bus_if.ifu_req_valid = 1'b1;
        bus_if.ifu_addr      = 32'h8000_0000;
        bus_if.mem_req_ready = 1'b1;
        #1;
        chkb("fetch ifu_req_ready", bus_if.ifu_req_ready, 1'b1);
        chkb("fetch lsu_req_ready", bus_if.lsu_req_ready, 1'b0);
        step();
        bus_if.ifu_req_valid = 1'b0;
        #1;
        chkb("fetch mem_req_valid", bus_if.mem_req_valid, 1'b1);
        chk("fetch mem_addr", bus_if.mem_addr, 32'h8000_0000);
        chkb("fetch mem_wen", bus_if.mem_wen, 1'b0);
        step();
        bus_if.mem_rsp_valid = 1'b1;
        bus_if.mem_rdata     = 32'h0000_0413;
        bus_if.ifu_req_valid = 1'b1;
        #1;
        chkb("fetch ifu_rsp_valid", bus_if.ifu_rsp_valid, 1'b1);
        chk("fetch ifu_rdata", bus_if.ifu_rdata, 32'h0000_0413);
        chkb("fetch no accept on rsp", bus_if.ifu_req_ready, 1'b0);
        step();
        bus_if.mem_rsp_valid = 1'b0;
        bus_if.ifu_req_valid = 1'b0;
        #1;
        chkb("fetch done busy", busy, 1'b0);
        step();

        // Simultaneous requests after reset: LSU first, then IFU.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_if.ifu_req_valid = 1'b1;
        bus_if.ifu_addr      = 32'h0000_0200;
        bus_if.lsu_req_valid = 1'b1;
        bus_if.lsu_addr      = 32'h0000_0100;
        bus_if.mem_req_ready = 1'b1;
        #1;
        chkb("rr1 lsu_req_ready", bus_if.lsu_req_ready, 1'b1);
        chkb("rr1 ifu_req_ready", bus_if.ifu_req_ready, 1'b0);
        step();
        bus_if.lsu_req_valid = 1'b0;
        #1;
        chk("rr1 mem_addr", bus_if.mem_addr, 32'h0000_0100);
        step();
        bus_if.mem_rsp_valid = 1'b1;
        bus_if.mem_rdata     = 32'h0000_0055;
        #1;
        chkb("rr1 lsu_rsp_valid", bus_if.lsu_rsp_valid, 1'b1);
        chk("rr1 lsu_rdata", bus_if.lsu_rdata, 32'h0000_0055);
        chkb("rr1 ifu_rsp_valid", bus_if.ifu_rsp_valid, 1'b0);
        step();
        bus_if.mem_rsp_valid = 1'b0;
        bus_if.lsu_req_valid = 1'b1;
        #1;
        chkb("rr2 ifu_req_ready", bus_if.ifu_req_ready, 1'b1);
        chkb("rr2 lsu_req_ready", bus_if.lsu_req_ready, 1'b0);
        step();
        bus_if.ifu_req_valid = 1'b0;
        bus_if.lsu_req_valid = 1'b0;
        #1;
        chk("rr2 mem_addr", bus_if.mem_addr, 32'h0000_0200);
        step();
        bus_if.mem_rsp_valid = 1'b1;
        bus_if.mem_rdata     = 32'h0000_0077;
        #1;
        chkb("rr2 ifu_rsp_valid", bus_if.ifu_rsp_valid, 1'b1);
        step();
        clear_inputs();

        // Spurious response in IDLE.
        bus_if.mem_rsp_valid = 1'b1;
        #1;
        chkb("spur idle ifu_rsp_valid", bus_if.ifu_rsp_valid, 1'b0);
        chkb("spur idle lsu_rsp_valid", bus_if.lsu_rsp_valid, 1'b0);
        step();
        chkb("spur idle busy", busy, 1'b0);

        // Store held off by mem_req_ready, with a spurious response while in REQ.
        bus_if.mem_rsp_valid = 1'b0;
        bus_if.lsu_req_valid = 1'b1;
        bus_if.lsu_wen       = 1'b1;
        bus_if.lsu_addr      = 32'h8000_1000;
        bus_if.lsu_wdata     = 32'hDEAD_BEEF;
        bus_if.lsu_wmask     = 4'hF;
        #1;
        chkb("store lsu_req_ready", bus_if.lsu_req_ready, 1'b1);
        step();
        bus_if.lsu_req_valid = 1'b0;
        bus_if.lsu_wdata     = 32'h1234_5678;
        bus_if.lsu_addr      = 32'h0;
        bus_if.mem_rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chkb("store mem_req_valid", bus_if.mem_req_valid, 1'b1);
            chk("store mem_addr", bus_if.mem_addr, 32'h8000_1000);
            chk("store mem_wdata", bus_if.mem_wdata, 32'hDEAD_BEEF);
            chk("store mem_wmask", 32'(bus_if.mem_wmask), 32'hF);
            chkb("store mem_wen", bus_if.mem_wen, 1'b1);
            chkb("spur req lsu_rsp_valid", bus_if.lsu_rsp_valid, 1'b0);
            step();
        end
        bus_if.mem_rsp_valid = 1'b0;
        bus_if.mem_req_ready = 1'b1;
        step();
        bus_if.mem_req_ready = 1'b0;
        bus_if.mem_rsp_valid = 1'b1;
        #1;
        chkb("store ack lsu_rsp_valid", bus_if.lsu_rsp_valid, 1'b1);
        chkb("store wait mem_req_valid", bus_if.mem_req_valid, 1'b0);
        chk("store wait mem_wdata", bus_if.mem_wdata, 32'hDEAD_BEEF);
        step();
        clear_inputs();
        step();

        // Reset while waiting for data; the late response must be dropped.
        bus_if.ifu_req_valid = 1'b1;
        bus_if.ifu_addr      = 32'h8000_0004;
        bus_if.mem_req_ready = 1'b1;
        step();
        bus_if.ifu_req_valid = 1'b0;
        step();
        chkb("rstwait busy before", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_if.mem_rsp_valid = 1'b1;
        bus_if.ifu_req_valid = 1'b1;
        bus_if.ifu_addr      = 32'h8000_0008;
        #1;
        chkb("rstwait ifu_rsp_valid", bus_if.ifu_rsp_valid, 1'b0);
        chkb("rstwait busy", busy, 1'b0);
        chkb("rstwait ifu_req_ready", bus_if.ifu_req_ready, 1'b1);
        step();
        bus_if.ifu_req_valid = 1'b0;
        bus_if.mem_rsp_valid = 1'b0;
        #1;
        chk("rstwait new mem_addr", bus_if.mem_addr, 32'h8000_0008);
        step();
        bus_if.mem_rsp_valid = 1'b1;
        bus_if.mem_rdata     = 32'h0000_0013;
        #1;
        chkb("rstwait new ifu_rsp_valid", bus_if.ifu_rsp_valid, 1'b1);
        step();
        clear_inputs();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
